// File: rtl/bf16_sched_pkg.sv
// Shared types and helpers for the bf16 adder scheduler.
package bf16_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } sched_state_t;

  // Result pattern returned when the adder never answers
  localparam logic [15:0] BF16_QNAN = 16'hFFFF;

  // Width of a requester index
  function automatic int bf16_sched_idx_w(input int nreq);
    return $clog2(nreq);
  endfunction

endpackage

// File: rtl/bf16_add_scheduler_rr_arbiter.sv
// Combinational cyclic-priority search: first asserted request at or after rr_ptr.
module rr_arbiter
  import bf16_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW  = bf16_sched_idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Walk offsets from farthest to nearest so the nearest hit is written last
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NREQ]) begin
        idx   = IW'((int'(rr_ptr) + k) % NREQ);
        grant = NREQ'(1) << ((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/bf16_add_scheduler.sv
// Round-robin scheduler sharing one bf16 adder between NREQ requesters.
// Optional watchdog on the adder response: define BF16_SCHED_TIMEOUT_EN.
module bf16_add_scheduler
  import bf16_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [15:0]       rsp_sum,
  output logic              rsp_err,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              add_start,
  output logic [15:0]       add_a,
  output logic [15:0]       add_b,
  input  logic              add_done,
  input  logic [15:0]       add_sum
);

  localparam int IW = bf16_sched_idx_w(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_cfg_chk
    $error("bf16_add_scheduler: NREQ must be 2..8 and TIMEOUT >= 1");
  end

  sched_state_t    state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   g;
  logic [NREQ-1:0] g_oh;
  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            rsp_take;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .grant  (arb_grant),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  // Only the granted requester's rsp_ready can close a response
  assign rsp_take = (state == RESP) && rsp_ready[g];

`ifdef BF16_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;
  logic          wd_fire;
  logic          rsp_err_q;

  assign wd_fire = (state == WAIT) && !add_done && (wd_cnt == CW'(TIMEOUT - 1));

  // Watchdog: counts cycles spent in WAIT, restarted on every issue
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)                wd_cnt <= '0;
    else if (state == ISSUE)    wd_cnt <= '0;
    else if (state == WAIT)     wd_cnt <= wd_cnt + 1'b1;
  end

  // Error flag rides along with the response and drops when it is consumed
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)       rsp_err_q <= 1'b0;
    else if (wd_fire)  rsp_err_q <= 1'b1;
    else if (rsp_take) rsp_err_q <= 1'b0;
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state: one operation at a time, no overlap
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (arb_any) state_nxt = GRANT;
      GRANT: state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (add_done) state_nxt = RESP;
`ifdef BF16_SCHED_TIMEOUT_EN
        else if (wd_fire) state_nxt = RESP;
`endif
      end
      RESP:  if (rsp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch, operand capture, result capture and pointer advance
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      g       <= '0;
      g_oh    <= '0;
      rr_ptr  <= '0;
      add_a   <= '0;
      add_b   <= '0;
      rsp_sum <= '0;
    end else begin
      if (state == IDLE && arb_any) begin
        g    <= arb_idx;
        g_oh <= arb_grant;
      end
      // Operands sampled here even if req_valid dropped since IDLE
      if (state == GRANT) begin
        add_a <= req_a[g*16 +: 16];
        add_b <= req_b[g*16 +: 16];
      end
      if (state == WAIT && add_done) rsp_sum <= add_sum;
`ifdef BF16_SCHED_TIMEOUT_EN
      else if (wd_fire)              rsp_sum <= BF16_QNAN;
`endif
      // Pointer moves only when a result is consumed
      if (rsp_take) rr_ptr <= (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
    end
  end

  // Handshake outputs decoded from registered state only
  always_comb begin
    req_ready = (state == GRANT) ? g_oh : '0;
    rsp_valid = (state == RESP)  ? g_oh : '0;
    add_start = (state == ISSUE);
  end

endmodule

// File: tb/tb_bf16_add_scheduler.sv
// Self-checking bench for bf16_add_scheduler: directed scenarios plus randomized traffic
// against a round-robin / bf16-arithmetic reference model.
module tb_bf16_add_scheduler;

  localparam int NREQ = 4;

  logic              clock = 1'b0;
  logic              nreset = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*16-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready, rsp_valid;
  logic [NREQ-1:0]   rsp_ready = '0;
  logic [15:0]       rsp_sum, add_a, add_b, add_sum;
  logic              rsp_err, add_start, add_done;

  logic [15:0] opa [NREQ];
  logic [15:0] opb [NREQ];

  int n_chk = 0;
  int n_err = 0;
  int ref_ptr = 0;

  always #5 clock = ~clock;

  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign req_a[i*16 +: 16] = opa[i];
    assign req_b[i*16 +: 16] = opb[i];
  end

  bf16_add_scheduler #(.NREQ(NREQ), .TIMEOUT(15)) dut (
    .clock     (clock),
    .nreset    (nreset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .add_start (add_start),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_done  (add_done),
    .add_sum   (add_sum)
  );

  // bf16 <-> double for normal, finite values
  function automatic real b2r(input logic [15:0] h);
    logic [63:0] d;
    d = {h[15], 11'(int'(h[14:7]) - 127 + 1023), h[6:0], 45'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [15:0] r2b(input real r);
    logic [63:0] d;
    logic [15:0] h;
    logic [44:0] rem;
    if (r == 0.0) return 16'h0000;
    d   = $realtobits(r);
    h   = {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:45]};
    rem = d[44:0];
    if (rem > (45'd1 << 44) || (rem == (45'd1 << 44) && h[0])) h = h + 16'd1;
    return h;
  endfunction

  function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
    return r2b(b2r(a) + b2r(b));
  endfunction

  function automatic logic [15:0] rnd_bf16();
    return {1'($urandom), 8'($urandom_range(135, 120)), 7'($urandom)};
  endfunction

  function automatic int ref_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  // Adder model: done 3 cycles after start, exact rounded bf16 sum
  logic        model_en = 1'b1;
  int          pend = 0;
  logic [15:0] m_a = '0, m_b = '0, m_sum = '0;
  logic        m_done = 1'b0;
  logic        spur = 1'b0;
  logic [15:0] spur_sum = '0;

  assign add_done = m_done | spur;
  assign add_sum  = spur ? spur_sum : m_sum;

  // Adder pipeline timing, evaluated on the falling edge
  always @(negedge clock) begin
    if (pend == 1) begin
      m_done <= 1'b1;
      m_sum  <= bf16_add(m_a, m_b);
    end else begin
      m_done <= 1'b0;
    end
    if (pend > 0) pend <= pend - 1;
    if (add_start && model_en) begin
      pend <= 3;
      m_a  <= add_a;
      m_b  <= add_b;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full operation. mode: 0 keep valid with new operands, 1 drop valid, 2 random traffic
  task automatic do_op(input int stall, input bit tied, input bit spur_g, input int mode,
                       output int gout);
    int g, w;
    logic [15:0] ea, eb, es;
    g = ref_pick(req_valid, ref_ptr);
    gout = g;
    w = 0;
    while (req_ready == '0 && w < 20) begin tick(); w++; end
    chk("grant", 32'(req_ready), 32'(oh(g)));
    if (req_ready == '0) return;
    ea = opa[g]; eb = opb[g]; es = bf16_add(ea, eb);
    if (spur_g) begin spur_sum = 16'h1234; spur = 1'b1; end
    tick();
    spur = 1'b0;
    chk("ready_pulse", 32'(req_ready), 0);
    chk("start", 32'(add_start), 1);
    chk("add_a", 32'(add_a), 32'(ea));
    chk("add_b", 32'(add_b), 32'(eb));
    case (mode)
      0: begin opa[g] = rnd_bf16(); opb[g] = rnd_bf16(); end
      1: req_valid[g] = 1'b0;
      default: begin
        opa[g] = rnd_bf16(); opb[g] = rnd_bf16();
        req_valid[g] = 1'($urandom);
        for (int j = 0; j < NREQ; j++)
          if (!req_valid[j] && $urandom_range(2) == 0) begin
            opa[j] = rnd_bf16(); opb[j] = rnd_bf16(); req_valid[j] = 1'b1;
          end
        if (req_valid == '0) req_valid[$urandom_range(NREQ - 1)] = 1'b1;
      end
    endcase
    tick();
    chk("start_pulse", 32'(add_start), 0);
    w = 0;
    while (rsp_valid == '0 && w < 40) begin tick(); w++; end
    chk("rsp_valid", 32'(rsp_valid), 32'(oh(g)));
    chk("rsp_sum", 32'(rsp_sum), 32'(es));
    chk("rsp_err", 32'(rsp_err), 0);
    for (int s = 0; s < stall; s++) begin
      rsp_ready = NREQ'($urandom) & ~oh(g);
      tick();
      chk("hold_valid", 32'(rsp_valid), 32'(oh(g)));
      chk("hold_sum", 32'(rsp_sum), 32'(es));
      chk("no_grant", 32'(req_ready), 0);
    end
    if (!tied) rsp_ready = oh(g);
    tick();
    chk("rsp_clear", 32'(rsp_valid), 0);
    if (!tied) rsp_ready = '0;
    ref_ptr = (g + 1) % NREQ;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    tick();
    tick();
    nreset = 1'b1;
    ref_ptr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int g, w;
    for (int i = 0; i < NREQ; i++) begin opa[i] = rnd_bf16(); opb[i] = rnd_bf16(); end

    // 1: reset values, then a single operation from requester 0
    #2;
    chk("rst_ctl", 32'({req_ready, rsp_valid, rsp_err, add_start}), 0);
    chk("rst_dat", 32'({add_a, add_b}), 0);
    chk("rst_sum", 32'(rsp_sum), 0);
    tick();
    nreset = 1'b1;
    tick();
    opa[0] = 16'h3F80; opb[0] = 16'h4000;
    req_valid = 4'b0001;
    do_op(0, 1'b0, 1'b0, 1, g);
    chk("t1_sum_const", 32'(rsp_sum), 32'h4040);

    // 2: all requesters valid, responses always accepted
    do_reset();
    req_valid = '1;
    rsp_ready = '1;
    for (int i = 0; i < 8; i++) begin
      do_op(0, 1'b1, 1'b0, 0, g);
      chk("rr_order", 32'(g), 32'(i % NREQ));
    end
    req_valid = '0;
    rsp_ready = '0;
    tick();

    // 3: long response stall, pointer must not move meanwhile
    req_valid = 4'b0101;
    do_op(10, 1'b0, 1'b0, 0, g);
    do_op(0, 1'b0, 1'b0, 0, g);
    do_op(0, 1'b0, 1'b0, 1, g);
    req_valid = '0;
    tick();

    // 5: spurious add_done in IDLE and in GRANT
    spur_sum = 16'h1234; spur = 1'b1;
    tick();
    spur = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("spur_idle", 32'({rsp_valid, req_ready, add_start}), 0);
    end
    req_valid = 4'b1000;
    do_op(0, 1'b0, 1'b1, 1, g);

    // 4: reset asserted in WAIT, late done afterwards must be ignored
    req_valid = 4'b0010;
    w = 0;
    while (req_ready == '0 && w < 20) begin tick(); w++; end
    chk("t4_grant", 32'(req_ready), 32'(oh(1)));
    tick();
    tick();
    nreset = 1'b0;
    #1;
    chk("t4_rst_ctl", 32'({req_ready, rsp_valid, rsp_err, add_start}), 0);
    chk("t4_rst_dat", 32'({add_a, add_b}), 0);
    chk("t4_rst_sum", 32'(rsp_sum), 0);
    req_valid = '0;
    tick();
    nreset = 1'b1;
    ref_ptr = 0;
    opa[2] = rnd_bf16(); opb[2] = rnd_bf16();
    req_valid = 4'b0100;
    do_op(0, 1'b0, 1'b0, 1, g);

    // Randomized traffic
    req_valid = NREQ'($urandom_range((1 << NREQ) - 1, 1));
    for (int i = 0; i < 30; i++)
      do_op($urandom_range(3), 1'b0, 1'b0, 2, g);
    req_valid = '0;
    tick();
    tick();

`ifdef BF16_SCHED_TIMEOUT_EN
    // 6: adder never answers, watchdog produces the error response
    model_en = 1'b0;
    req_valid = 4'b0001;
    g = ref_pick(req_valid, ref_ptr);
    w = 0;
    while (req_ready == '0 && w < 20) begin tick(); w++; end
    chk("t6_grant", 32'(req_ready), 32'(oh(g)));
    req_valid = '0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 16) chk("t6_early", 32'(rsp_valid), 0);
    end
    chk("t6_valid", 32'(rsp_valid), 32'(oh(g)));
    chk("t6_sum", 32'(rsp_sum), 32'hFFFF);
    chk("t6_err", 32'(rsp_err), 1);
    rsp_ready = oh(g);
    tick();
    rsp_ready = '0;
    chk("t6_clear", 32'({rsp_valid, rsp_err}), 0);
    model_en = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
